// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock control front end.
// Mode encoding and the default debounce length.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_ADJ_MIN = 2'd1,
        MODE_ADJ_HR  = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    localparam int DB_CYCLES_DEF = 4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter
// and a single-cycle press pulse on each debounced rising level.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DB_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic            stable_dly_q;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/time_adjust_ctrl.sv
// Mode FSM and counter-enable drivers for the digital clock.
// RUN cascades the 1 Hz tick; adjust modes issue single steps.
module time_adjust_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DB_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       sec_en,
    output logic       sec_updown,
    output logic       min_en,
    output logic       min_updown,
    output logic       hr_en,
    output logic       hr_updown,
    output logic [1:0] mode,
    output logic       adj_led
);

    logic  p_mode;
    logic  p_up;
    logic  p_down;
    logic  step;

    mode_e mode_q,    mode_d;
    logic  adj_led_q, adj_led_d;
    logic  sec_en_q,  sec_en_d;
    logic  min_en_q,  min_en_d;
    logic  hr_en_q,   hr_en_d;
    logic  sec_ud_q,  sec_ud_d;
    logic  min_ud_q,  min_ud_d;
    logic  hr_ud_q,   hr_ud_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_mode (
        .clk(clk), .rst_n(reset), .btn_raw(btn_mode), .press(p_mode)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_up (
        .clk(clk), .rst_n(reset), .btn_raw(btn_up), .press(p_up)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_down (
        .clk(clk), .rst_n(reset), .btn_raw(btn_down), .press(p_down)
    );

    // A step needs exactly one direction and no competing mode press.
    assign step = (p_up ^ p_down) & ~p_mode;

    always_comb begin
        mode_d   = mode_q;
        sec_en_d = 1'b0;
        min_en_d = 1'b0;
        hr_en_d  = 1'b0;
        sec_ud_d = sec_ud_q;
        min_ud_d = min_ud_q;
        hr_ud_d  = hr_ud_q;
        case (mode_q)
            MODE_RUN: begin
                sec_en_d = tick_1hz;
                min_en_d = tick_1hz & sec_max;
                hr_en_d  = tick_1hz & sec_max & min_max;
                sec_ud_d = 1'b1;
                min_ud_d = 1'b1;
                hr_ud_d  = 1'b1;
                if (p_mode) mode_d = MODE_ADJ_MIN;
            end
            MODE_ADJ_MIN: begin
                if (p_mode) begin
                    mode_d = MODE_ADJ_HR;
                end else if (step) begin
                    min_en_d = 1'b1;
                    min_ud_d = p_up;
                end
            end
            MODE_ADJ_HR: begin
                if (p_mode) begin
                    mode_d = MODE_RUN;
                end else if (step) begin
                    hr_en_d = 1'b1;
                    hr_ud_d = p_up;
                end
            end
            default: mode_d = MODE_RUN;
        endcase
        adj_led_d = (mode_d == MODE_ADJ_MIN) || (mode_d == MODE_ADJ_HR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= MODE_RUN;
            adj_led_q <= 1'b0;
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            hr_en_q   <= 1'b0;
            sec_ud_q  <= 1'b0;
            min_ud_q  <= 1'b0;
            hr_ud_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            adj_led_q <= adj_led_d;
            sec_en_q  <= sec_en_d;
            min_en_q  <= min_en_d;
            hr_en_q   <= hr_en_d;
            sec_ud_q  <= sec_ud_d;
            min_ud_q  <= min_ud_d;
            hr_ud_q   <= hr_ud_d;
        end
    end

    assign mode       = mode_q;
    assign adj_led    = adj_led_q;
    assign sec_en     = sec_en_q;
    assign min_en     = min_en_q;
    assign hr_en      = hr_en_q;
    assign sec_updown = sec_ud_q;
    assign min_updown = min_ud_q;
    assign hr_updown  = hr_ud_q;

endmodule

// File: doc/time_adjust_ctrl.md
Name: time_adjust_ctrl

Overview:
- Control front end for the digital-clock datapath. It is the initiator that drives the `en`/`updown` inputs of the seconds, minutes and hours modulo counters.
- Debounces three push-buttons and runs a RUN / ADJ_MIN / ADJ_HR mode FSM.
- In RUN it cascades the 1 Hz tick through the counters using their at-max flags.
- In the adjust modes it issues single up/down step pulses to the selected field.

Parameters:
- DB_CYCLES, 4, consecutive synced cycles a raw button must differ from its stable level before the stable level flips. Use 4 in simulation, about 500000 on board.
- DB_W, 20, width of the debounce counter. Must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk  in  1  system clock; all flops on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- tick_1hz  in  1  one-cycle pulse from the prescaler; successive ticks are spaced at least 2 cycles apart.
- btn_mode  in  1  raw, asynchronous, bouncing mode button.
- btn_up  in  1  raw up button.
- btn_down  in  1  raw down button.
- sec_max  in  1  high while the seconds counter equals its modulus-1.
- min_max  in  1  high while the minutes counter equals its modulus-1.
- sec_en  out  1  seconds counter enable.
- sec_updown  out  1  seconds direction (1=up).
- min_en  out  1  minutes counter enable.
- min_updown  out  1  minutes direction.
- hr_en  out  1  hours counter enable.
- hr_updown  out  1  hours direction.
- mode  out  2  current mode (encoding from package).
- adj_led  out  1  high in any adjust mode.

Behaviour:
- Reset: all outputs are registered and reset to 0.
  - mode=RUN, adj_led=0, every en=0, every updown=0.
  - Debounce stable levels = 0, debounce counters = 0, synchronisers = 0.
  - A reset asserted mid-operation takes effect immediately, in any mode.
- Button conditioning, per button:
  - 2-FF synchroniser.
  - Debounce counter counts while the synced value != stable level; it clears to 0 whenever they are equal.
  - When the count reaches DB_CYCLES, stable takes the synced value and the counter clears.
  - Press pulse = stable & ~stable_q, high for exactly one cycle per debounced press.
  - Raw rising edge first sampled at edge k → stable high after edge k+1+DB_CYCLES → press pulse high in the following cycle.
  - Release produces no pulse. No auto-repeat: a held button gives one pulse.
  - A button held through reset release produces one pulse after debounce.
- Mode FSM:
  - RUN → ADJ_MIN → ADJ_HR → RUN, advancing on each mode press.
  - mode and adj_led update at the edge ending the press-pulse cycle.
- RUN, registered outputs updated at the edge ending the tick cycle:
  - sec_en = tick.
  - min_en = tick & sec_max.
  - hr_en = tick & sec_max & min_max.
  - All updown = 1.
  - Up/down presses are ignored.
- ADJ_MIN / ADJ_HR:
  - tick ignored; the seconds counter is frozen (sec_en=0).
  - An up press gives the selected field's en=1 for one cycle with updown=1.
  - A down press gives en=1 for one cycle with updown=0.
  - The non-selected fields keep en=0.
- Simultaneous events:
  - Up and down presses in the same cycle: both ignored, no en.
  - Mode press in the same cycle as an up/down press: the mode change wins and the step is dropped.
  - Mode press in the same cycle as a tick in RUN: the tick cascade is still issued and the mode advances.
- updown outputs hold their last value when en=0. In RUN they are forced to 1.
- mode value 2'd3 is unreachable; if entered, the FSM returns to RUN on the next edge and all en=0.

Decomposition:
- Package clock_pkg:
  - Mode encoding: MODE_RUN=2'd0, MODE_ADJ_MIN=2'd1, MODE_ADJ_HR=2'd2.
  - Default DB_CYCLES constant.
- Sub-module btn_debounce (synchroniser + debounce counter + press pulse), instantiated three times.
- FSM and output registers live in time_adjust_ctrl.

Test Plan:
- Reset: hold reset=0 with buttons and tick toggling → all en=0, mode=0, adj_led=0 throughout. Release → outputs stay 0 with no tick.
- RUN cascade, single field: tick with sec_max=0 → next cycle sec_en=1 for 1 cycle, sec_updown=1, min_en=0, hr_en=0.
- RUN cascade, full carry: tick with sec_max=1, min_max=1 → sec_en, min_en and hr_en all 1 for exactly 1 cycle.
- Debounce: btn_mode high for 3 cycles then low → mode stays 0. Then hold high for 10 cycles → mode=1 after exactly DB_CYCLES+3 edges from the first sampled high, single transition, adj_led=1.
- Adjust step: in ADJ_MIN, press btn_down → min_en=1 for one cycle, min_updown=0, sec_en=hr_en=0. A tick with sec_max=1 in this mode → no en at all.
- Conflicts and reset: up and down pressed together in ADJ_HR → no en. Mode press coincident with up → mode=RUN, no hr_en. Drive reset=0 mid-ADJ_HR → mode=0 without a clock edge.
